// File: rtl/uart_fifo_gen.sv
// Parametrised UART character FIFO with circular pointers, optional per-entry error tag,
// flush, occupancy count, trigger threshold and single-entry (16450) mode.
module uart_fifo_gen #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int TAG_EN = 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [DATA_W-1:0] din,
  input  logic              tag_in,
  output logic [DATA_W-1:0] dout,
  output logic              tag_out,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  input  logic [CW-1:0]     threshold,
  output logic              thre_trigger,
  output logic              overrun,
  output logic              underrun,
  output logic              err_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cap;
  logic              pop_ok;
  logic              push_ok;
  logic              head_tag;

  assign cap = en ? CW'(DEPTH) : CW'(1);

  // full uses >= so that entries kept across an en 1->0 switch still block pushes
  assign empty   = (cnt == '0);
  assign full    = (cnt >= cap);
  assign pop_ok  = pop_in & ~empty;
  assign push_ok = push_in & (~full | pop_ok);

  assign count        = cnt;
  assign thre_trigger = (threshold != '0) && (cnt >= threshold);
  assign dout         = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      overrun  <= push_in & ~push_ok;
      underrun <= pop_in & empty;
    end
  end

  if (TAG_EN != 0) begin : g_tag
    logic          tag_mem [DEPTH];
    logic [CW-1:0] tag_cnt;

    assign head_tag    = tag_mem[rd_ptr];
    assign tag_out     = ~empty & head_tag;
    assign err_pending = (tag_cnt != '0);

    always_ff @(posedge clk) begin
      if (!rst && !flush && push_ok) begin
        tag_mem[wr_ptr] <= tag_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        tag_cnt <= '0;
      end else begin
        case ({push_ok & tag_in, pop_ok & head_tag})
          2'b10:   tag_cnt <= tag_cnt + CW'(1);
          2'b01:   tag_cnt <= tag_cnt - CW'(1);
          default: tag_cnt <= tag_cnt;
        endcase
      end
    end
  end else begin : g_notag
    logic unused_tag;
    assign unused_tag  = tag_in;
    assign head_tag    = 1'b0;
    assign tag_out     = 1'b0;
    assign err_pending = 1'b0;
  end

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed bench for uart_fifo_gen: stimulus queues expected head data, a negedge monitor
// compares dout/tag_out on every accepted pop; flag checks are done inline.
module tb_uart_fifo_gen;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst, en, flush, push_in, pop_in, tag_in;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          tag_out, empty, full, thre_trigger, overrun, underrun, err_pending;
  logic [CW-1:0] count, threshold;

  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q [$];

  uart_fifo_gen #(.DATA_W(DW), .DEPTH(DP), .TAG_EN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .push_in(push_in), .pop_in(pop_in),
    .din(din), .tag_in(tag_in), .dout(dout), .tag_out(tag_out), .empty(empty), .full(full),
    .count(count), .threshold(threshold), .thre_trigger(thre_trigger), .overrun(overrun),
    .underrun(underrun), .err_pending(err_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: head is consumed at the coming edge, so dout must match the queue front now.
  always @(negedge clk) begin
    if (!rst && !flush && pop_in && !empty) begin
      if (exp_q.size() == 0) begin
        check("pop_with_no_expected_entry", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("pop_dout", 32'(dout), 32'(exp_q[0][DW-1:0]));
        check("pop_tag", 32'(tag_out), 32'(exp_q[0][DW]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic pu, input logic po, input logic [DW-1:0] d, input logic t);
    push_in = pu; pop_in = po; din = d; tag_in = t;
    @(posedge clk);
    #1;
    push_in = 1'b0; pop_in = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic t);
    exp_q.push_back({t, d});
    cyc(1'b1, 1'b0, d, t);
  endtask

  task automatic check_reset_state(input string tagname);
    check({tagname, "_empty"}, 32'(empty), 1);
    check({tagname, "_full"}, 32'(full), 0);
    check({tagname, "_count"}, 32'(count), 0);
    check({tagname, "_thre"}, 32'(thre_trigger), 0);
    check({tagname, "_err"}, 32'(err_pending), 0);
    check({tagname, "_dout"}, 32'(dout), 0);
    check({tagname, "_tag_out"}, 32'(tag_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    din = '0; tag_in = 1'b0; threshold = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_overrun", 32'(overrun), 0);
    check("reset_underrun", 32'(underrun), 0);
    rst = 1'b0;

    // fill to capacity, then one rejected push
    for (int i = 0; i < 16; i++) push_exp(8'(8'h11 + i), 1'b0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    cyc(1'b1, 1'b0, 8'h99, 1'b0);
    check("ovr_pulse", 32'(overrun), 1);
    check("ovr_dout", 32'(dout), 8'h11);
    check("ovr_count", 32'(count), 16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("ovr_one_cycle", 32'(overrun), 0);

    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("udr_pulse", 32'(underrun), 1);
    check("udr_count", 32'(count), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("udr_one_cycle", 32'(underrun), 0);

    // simultaneous push/pop when full, then when empty
    for (int i = 0; i < 16; i++) push_exp(8'(8'h11 + i), 1'b0);
    exp_q.push_back({1'b0, 8'hAA});
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    check("fullpp_count", 32'(count), 16);
    check("fullpp_overrun", 32'(overrun), 0);
    check("fullpp_dout", 32'(dout), 8'h12);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("fullpp_drained", 32'(empty), 1);
    exp_q.push_back({1'b0, 8'h77});
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    check("emptypp_count", 32'(count), 1);
    check("emptypp_underrun", 32'(underrun), 1);
    check("emptypp_dout", 32'(dout), 8'h77);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("emptypp_drained", 32'(empty), 1);

    // threshold behaviour
    threshold = 5'd4;
    for (int i = 1; i <= 3; i++) push_exp(8'(i), 1'b0);
    check("thr_below", 32'(thre_trigger), 0);
    push_exp(8'd4, 1'b0);
    check("thr_reached", 32'(thre_trigger), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("thr_fall", 32'(thre_trigger), 0);
    threshold = 5'd2;
    #1 check("thr_live_change", 32'(thre_trigger), 1);
    threshold = 5'd0;
    #1 check("thr_disabled", 32'(thre_trigger), 0);
    threshold = 5'd17;
    #1 check("thr_above_depth", 32'(thre_trigger), 0);
    threshold = 5'd0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("thr_drained", 32'(empty), 1);

    // RX tag tracking
    push_exp(8'h41, 1'b0);
    push_exp(8'h42, 1'b1);
    push_exp(8'h43, 1'b0);
    check("tag_pending", 32'(err_pending), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("tag_after_pop1", 32'(err_pending), 1);
    check("tag_head", 32'(tag_out), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("tag_after_pop2", 32'(err_pending), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // flush with 5 entries (two tagged) and a coincident push
    for (int i = 0; i < 5; i++) push_exp(8'(8'h60 + i), 1'(i & 1));
    check("preflush_count", 32'(count), 5);
    check("preflush_err", 32'(err_pending), 1);
    flush = 1'b1;
    exp_q.delete();
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    flush = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_overrun", 32'(overrun), 0);
    check("flush_err", 32'(err_pending), 0);

    // non-FIFO mode
    en = 1'b0;
    push_exp(8'h55, 1'b0);
    check("nf_full", 32'(full), 1);
    check("nf_count", 32'(count), 1);
    cyc(1'b1, 1'b0, 8'h66, 1'b0);
    check("nf_overrun", 32'(overrun), 1);
    check("nf_dout", 32'(dout), 8'h55);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("nf_drained", 32'(empty), 1);

    // entries kept across en 1->0
    en = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(8'(8'h30 + i), 1'b0);
    en = 1'b0;
    #1 check("nf_keep_full", 32'(full), 1);
    check("nf_keep_count", 32'(count), 3);
    cyc(1'b1, 1'b0, 8'h99, 1'b0);
    check("nf_keep_overrun", 32'(overrun), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("nf_keep_drained", 32'(empty), 1);
    check("nf_keep_notfull", 32'(full), 0);

    // reset mid-stream
    en = 1'b1;
    for (int i = 0; i < 7; i++) push_exp(8'(8'h80 + i), 1'(i == 2));
    check("prerst_count", 32'(count), 7);
    rst = 1'b1;
    exp_q.delete();
    cyc(1'b1, 1'b1, 8'hCC, 1'b1);
    rst = 1'b0;
    check_reset_state("midrst");

    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("queue_consumed", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
